// File: rtl/issue_select_rr_pkg.sv
// Shared sizing constants for the issue-queue select stage.
// Defaults follow the issue-queue entry count.
package issue_select_rr_pkg;

    localparam int ISSUE_QUEUE_ENTRIES     = 32;
    localparam int ISSUE_QUEUE_ENTRIES_LOG = 5;

endpackage

// File: rtl/issue_select_rr_pick.sv
// select_priority_pick: find-first-set from a start index, wrapping
// past the top entry back to zero; result is one-hot or all-zero.
module select_priority_pick
    import issue_select_rr_pkg::*;
#(
    parameter int ENTRIES     = ISSUE_QUEUE_ENTRIES,
    parameter int ENTRIES_LOG = ISSUE_QUEUE_ENTRIES_LOG
) (
    input  logic [ENTRIES-1:0]     vector_i,
    input  logic [ENTRIES_LOG-1:0] start_i,
    output logic [ENTRIES-1:0]     grant_o
);

    localparam int SW = ENTRIES_LOG + 1;
    localparam logic [SW-1:0] NUM = SW'(ENTRIES);

    // Scan upward from start_i, first set bit wins.
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            idx = {1'b0, start_i} + SW'(i);
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (!found && vector_i[idx[ENTRIES_LOG-1:0]]) begin
                grant_o[idx[ENTRIES_LOG-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select_rr.sv
// issue_select_rr: registered select stage for one issue port.
// ISSUE_SELECT_RR_EN selects round-robin; otherwise fixed priority.
module issue_select_rr
    import issue_select_rr_pkg::*;
#(
    parameter int ENTRIES     = ISSUE_QUEUE_ENTRIES,
    parameter int ENTRIES_LOG = ISSUE_QUEUE_ENTRIES_LOG
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush_i,
    input  logic [ENTRIES-1:0] requestVector_i,
    input  logic               grantReady_i,
    output logic [ENTRIES-1:0] grantVector_o,
    output logic               grantValid_o
);

    logic [ENTRIES-1:0]     grant_q, grant_d;
    logic                   valid_q, valid_d;
    logic [ENTRIES-1:0]     lastMask_q, lastMask_d;
    logic [ENTRIES-1:0]     selMask;
    logic [ENTRIES-1:0]     effReq;
    logic [ENTRIES-1:0]     pick;
    logic [ENTRIES_LOG-1:0] pickStart;
    logic                   transfer;
    logic                   load;

    assign transfer = valid_q & grantReady_i;
    assign load     = ~valid_q | transfer;

    // The entry leaving this cycle is excluded from the refill pick;
    // otherwise the entry that left last cycle is still blocked.
    assign selMask = transfer ? grant_q : lastMask_q;
    assign effReq  = requestVector_i & ~selMask;

`ifdef ISSUE_SELECT_RR_EN
    logic [ENTRIES_LOG-1:0] ptr_q, ptr_d;
    logic [ENTRIES_LOG-1:0] grantIdx;
    logic [ENTRIES_LOG-1:0] ptrNext;

    // One-hot to index of the held grant.
    always_comb begin
        grantIdx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant_q[i]) begin
                grantIdx = ENTRIES_LOG'(i);
            end
        end
    end

    assign ptrNext = (grantIdx == ENTRIES_LOG'(ENTRIES - 1))
                   ? '0 : grantIdx + ENTRIES_LOG'(1);

    assign pickStart = transfer ? ptrNext : ptr_q;

    // Pointer moves past a transferred entry unless flushed.
    always_comb begin
        ptr_d = ptr_q;
        if (!flush_i && transfer) begin
            ptr_d = ptrNext;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pickStart = '0;
`endif

    select_priority_pick #(
        .ENTRIES     (ENTRIES),
        .ENTRIES_LOG (ENTRIES_LOG)
    ) u_pick (
        .vector_i (effReq),
        .start_i  (pickStart),
        .grant_o  (pick)
    );

    // Next grant, valid and last-transfer mask; flush wins.
    always_comb begin
        grant_d    = grant_q;
        valid_d    = valid_q;
        lastMask_d = '0;
        if (flush_i) begin
            grant_d = '0;
            valid_d = 1'b0;
        end else begin
            if (load) begin
                grant_d = pick;
                valid_d = |pick;
            end
            if (transfer) begin
                lastMask_d = grant_q;
            end
        end
    end

    // Grant, valid and mask registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_q    <= '0;
            valid_q    <= 1'b0;
            lastMask_q <= '0;
        end else begin
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            lastMask_q <= lastMask_d;
        end
    end

    assign grantVector_o = grant_q;
    assign grantValid_o  = valid_q;

endmodule

// File: tb/tb_issue_select_rr.sv
// Directed table-driven bench for issue_select_rr with 8 entries.
// Expectations follow the build: round-robin or fixed priority.
module tb_issue_select_rr;

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] g;
        logic       v;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       flush_i;
    logic [7:0] requestVector_i;
    logic       grantReady_i;
    logic [7:0] grantVector_o;
    logic       grantValid_o;

    int   tests;
    int   fails;
    vec_t vecs[$];

    issue_select_rr #(
        .ENTRIES     (8),
        .ENTRIES_LOG (3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush_i         (flush_i),
        .requestVector_i (requestVector_i),
        .grantReady_i    (grantReady_i),
        .grantVector_o   (grantVector_o),
        .grantValid_o    (grantValid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic f,
                       input logic [7:0] q, input logic y,
                       input logic [7:0] g, input logic v);
        vec_t t;
        t.rst_n = r;
        t.flush = f;
        t.req   = q;
        t.rdy   = y;
        t.g     = g;
        t.v     = v;
        vecs.push_back(t);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        flush_i = 1'b0;
        requestVector_i = 8'h00;
        grantReady_i = 1'b0;

        // rst, flush, req, rdy -> grant, valid after the edge
        add(0, 0, 8'hFF, 1, 8'h00, 0);
        add(0, 0, 8'hFF, 1, 8'h00, 0);
        add(0, 0, 8'hFF, 1, 8'h00, 0);
        add(1, 0, 8'hFF, 0, 8'h01, 1);
`ifdef ISSUE_SELECT_RR_EN
        // masking and pointer: 0x14 gives 04, 10, 04
        add(1, 0, 8'h14, 1, 8'h04, 1);
        add(1, 0, 8'h14, 1, 8'h10, 1);
        add(1, 0, 8'h14, 1, 8'h04, 1);
        // stall hold while request moves to 0x80
        add(1, 0, 8'h80, 0, 8'h04, 1);
        add(1, 0, 8'h80, 0, 8'h04, 1);
        add(1, 0, 8'h80, 0, 8'h04, 1);
        add(1, 0, 8'h80, 1, 8'h80, 1);
        // grant entry 6, then wrap with 0x81
        add(1, 0, 8'h40, 1, 8'h40, 1);
        add(1, 0, 8'h81, 1, 8'h80, 1);
        add(1, 0, 8'h81, 1, 8'h01, 1);
        // flush with transfer of 0x08; ptr stays 1 so 0x09 picks 08
        add(1, 0, 8'h08, 1, 8'h08, 1);
        add(1, 1, 8'h08, 1, 8'h00, 0);
        add(1, 0, 8'h09, 1, 8'h08, 1);
        // empty request, then just-issued entry blocked one cycle
        add(1, 0, 8'h00, 1, 8'h00, 0);
        add(1, 0, 8'h08, 1, 8'h00, 0);
        add(1, 0, 8'h08, 0, 8'h08, 1);
        // reset mid-stall
        add(0, 0, 8'h08, 0, 8'h00, 0);
        add(1, 0, 8'h81, 0, 8'h01, 1);
`else
        // fixed priority alternation on 0x81
        add(1, 0, 8'h81, 1, 8'h80, 1);
        add(1, 0, 8'h81, 1, 8'h01, 1);
        add(1, 0, 8'h81, 1, 8'h80, 1);
        // stall hold while request changes
        add(1, 0, 8'h81, 0, 8'h80, 1);
        add(1, 0, 8'h00, 0, 8'h80, 1);
        add(1, 0, 8'h06, 0, 8'h80, 1);
        add(1, 0, 8'h06, 1, 8'h02, 1);
        add(1, 0, 8'h06, 1, 8'h04, 1);
        // empty request, then just-issued entry blocked one cycle
        add(1, 0, 8'h00, 1, 8'h00, 0);
        add(1, 0, 8'h04, 1, 8'h00, 0);
        add(1, 0, 8'h04, 0, 8'h04, 1);
        // flush with transfer, then reload unmasked
        add(1, 1, 8'h04, 1, 8'h00, 0);
        add(1, 0, 8'h04, 1, 8'h04, 1);
        // flush during stall
        add(1, 1, 8'hFF, 0, 8'h00, 0);
        add(1, 0, 8'hFF, 0, 8'h01, 1);
        // reset mid-stall
        add(0, 0, 8'hFF, 0, 8'h00, 0);
        add(1, 0, 8'h10, 0, 8'h10, 1);
        add(1, 0, 8'h10, 1, 8'h00, 0);
        add(1, 0, 8'h20, 1, 8'h20, 1);
        add(1, 0, 8'h00, 1, 8'h00, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n         = vecs[i].rst_n;
            flush_i         = vecs[i].flush;
            requestVector_i = vecs[i].req;
            grantReady_i    = vecs[i].rdy;
            @(posedge clk);
            #1;
            tests++;
            if (grantVector_o !== vecs[i].g) begin
                fails++;
                $display("FAIL row %0d grant: got %02h expected %02h",
                         i, grantVector_o, vecs[i].g);
            end
            tests++;
            if (grantValid_o !== vecs[i].v) begin
                fails++;
                $display("FAIL row %0d valid: got %0b expected %0b",
                         i, grantValid_o, vecs[i].v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
